// File: rtl/sample_dac_pkg.sv
// Shared types and constants for the sample_dac audio output stage.
package sample_dac_pkg;

    localparam int          DATA_W_DEF       = 16;
    localparam logic [15:0] MIDSCALE_OFFSET  = 16'h8000;
    localparam logic [7:0]  UNDERRUN_CNT_MAX = 8'd255;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sample_dac_dsm1.sv
// First-order delta-sigma modulator: the carry out of a running offset-binary
// accumulation is the pulse-density bit.
module dsm1 #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] u,
    output logic         dac_o
);

    logic [W-1:0] acc;
    logic [W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, u};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc   <= '0;
            dac_o <= 1'b0;
        end else begin
            acc   <= sum[W-1:0];
            dac_o <= sum[W];
        end
    end

endmodule

// File: rtl/sample_dac.sv
// Tick-paced sample release with one-entry pending buffer, feeding dsm1.
// Optional underrun counter enabled by defining SAMPLE_DAC_UNDERRUN_CNT_EN.
module sample_dac
    import sample_dac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              tick_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              dac_o,
    output logic              underrun_o
`ifdef SAMPLE_DAC_UNDERRUN_CNT_EN
    ,
    output logic [7:0]        underrun_cnt_o
`endif
);

    // Flipping the sign bit maps two's complement onto offset binary.
    localparam logic [DATA_W-1:0] SIGN_FLIP = {1'b1, {(DATA_W-1){1'b0}}};

    state_e            state, state_next;
    logic [DATA_W-1:0] pend, cur, u;
    logic              pend_vld;
    logic              take, load_cur, underrun_next;

    assign ready_o = !pend_vld;
    assign take    = valid_i && ready_o;

    always_comb begin
        state_next    = state;
        load_cur      = 1'b0;
        underrun_next = 1'b0;
        if (tick_i) begin
            case (state)
                IDLE: begin
                    if (pend_vld) begin
                        load_cur   = 1'b1;
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (pend_vld) load_cur      = 1'b1;
                    else          underrun_next = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // take and load_cur are exclusive: take needs pend_vld=0, load_cur needs 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            pend       <= '0;
            pend_vld   <= 1'b0;
            cur        <= '0;
            underrun_o <= 1'b0;
        end else begin
            state      <= state_next;
            underrun_o <= underrun_next;
            if (load_cur) cur <= pend;
            if (take) begin
                pend     <= sample_i;
                pend_vld <= 1'b1;
            end else if (load_cur) begin
                pend_vld <= 1'b0;
            end
        end
    end

`ifdef SAMPLE_DAC_UNDERRUN_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            underrun_cnt_o <= 8'd0;
        end else if (underrun_next && underrun_cnt_o != UNDERRUN_CNT_MAX) begin
            underrun_cnt_o <= underrun_cnt_o + 8'd1;
        end
    end
`endif

    assign u = cur ^ SIGN_FLIP;

    dsm1 #(.W(DATA_W)) u_dsm (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .u      (u),
        .dac_o  (dac_o)
    );

endmodule

// File: tb/tb_sample_dac.sv
// Directed self-checking bench for sample_dac; define SAMPLE_DAC_UNDERRUN_CNT_EN
// to also cover the underrun counter.
module tb_sample_dac;
    import sample_dac_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        tick_i = 1'b0;
    logic [15:0] sample_i = 16'h0000;
    logic        valid_i = 1'b0;
    logic        ready_o, dac_o, underrun_o;
`ifdef SAMPLE_DAC_UNDERRUN_CNT_EN
    logic [7:0]  underrun_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] SMP_A = 16'h1234;
    localparam logic [15:0] SMP_B = 16'h5678;
    localparam logic [15:0] SMP_C = 16'hA5C3;
    localparam logic [15:0] SMP_D = 16'h0F0F;

    sample_dac dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .tick_i     (tick_i),
        .sample_i   (sample_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .dac_o      (dac_o),
        .underrun_o (underrun_o)
`ifdef SAMPLE_DAC_UNDERRUN_CNT_EN
        ,
        .underrun_cnt_o (underrun_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Called at a negedge; returns at the negedge after the tick edge.
    task automatic do_tick();
        tick_i = 1'b1;
        @(negedge clk_i);
        tick_i = 1'b0;
        $display("tick  cur=%h underrun=%b ready=%b", dut.cur, underrun_o, ready_o);
    endtask

    task automatic push(input logic [15:0] s);
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL push_ready_before: got %b expected 1", ready_o);
        end
        sample_i = s;
        valid_i  = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL push_ready_after: got %b expected 0", ready_o);
        end
        $display("push  sample=%h ready=%b", s, ready_o);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b1 || dac_o !== 1'b0 || underrun_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b dac=%b underrun=%b expected 1 0 0",
                     ready_o, dac_o, underrun_o);
        end
        checks++;
        if (dut.state !== IDLE || dut.cur !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: got state=%b cur=%h expected IDLE 0000", dut.state, dut.cur);
        end
        rst_ni = 1'b1;
        $display("reset released");
    endtask

    task automatic test_idle_midscale();
        int ones, rdy_bad, und_seen;
        for (int w = 0; w < 5; w++) begin
            ones = 0; rdy_bad = 0; und_seen = 0;
            for (int i = 0; i < 1000; i++) begin
                tick_i = (i == 500);
                @(negedge clk_i);
                if (dac_o === 1'b1) ones++;
                if (ready_o !== 1'b1) rdy_bad++;
                if (underrun_o !== 1'b0) und_seen++;
            end
            tick_i = 1'b0;
            checks++;
            if (ones != 500) begin
                errors++;
                $display("FAIL idle_density window %0d: got %0d expected 500", w, ones);
            end
            checks++;
            if (rdy_bad != 0 || und_seen != 0) begin
                errors++;
                $display("FAIL idle_flags window %0d: got ready_low=%0d underrun=%0d expected 0 0",
                         w, rdy_bad, und_seen);
            end
            $display("idle window %0d ones=%0d", w, ones);
        end
    endtask

    task automatic test_extreme(input logic [15:0] s, input int min_ones, input int max_ones);
        int ones;
        push(s);
        do_tick();
        checks++;
        if (ready_o !== 1'b1 || underrun_o !== 1'b0) begin
            errors++;
            $display("FAIL extreme_tick %h: got ready=%b underrun=%b expected 1 0", s, ready_o, underrun_o);
        end
        ones = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_i);
            if (dac_o === 1'b1) ones++;
        end
        checks++;
        if (ones < min_ones || ones > max_ones) begin
            errors++;
            $display("FAIL extreme_density %h: got %0d expected %0d..%0d", s, ones, min_ones, max_ones);
        end
        $display("sample %h ones=%0d", s, ones);
    endtask

    task automatic test_back_to_back();
        int rdy_bad;
        sample_i = SMP_A;
        valid_i  = 1'b1;
        @(negedge clk_i);
        sample_i = SMP_B;
        rdy_bad = 0;
        repeat (4) begin
            @(negedge clk_i);
            if (ready_o !== 1'b0) rdy_bad++;
        end
        checks++;
        if (rdy_bad != 0) begin
            errors++;
            $display("FAIL b2b_wait: got ready_high=%0d expected 0", rdy_bad);
        end
        do_tick();
        checks++;
        if (ready_o !== 1'b1 || dut.cur !== SMP_A) begin
            errors++;
            $display("FAIL b2b_after_tick: got ready=%b cur=%h expected 1 %h", ready_o, dut.cur, SMP_A);
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept_b: got ready=%b expected 0", ready_o);
        end
        do_tick();
        checks++;
        if (dut.cur !== SMP_B || underrun_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_cur_b: got cur=%h underrun=%b expected %h 0", dut.cur, underrun_o, SMP_B);
        end
    endtask

    task automatic test_underrun();
        @(negedge clk_i);
        checks++;
        if (underrun_o !== 1'b0) begin
            errors++;
            $display("FAIL underrun_pre: got %b expected 0", underrun_o);
        end
        do_tick();
        checks++;
        if (underrun_o !== 1'b1 || dut.cur !== SMP_B) begin
            errors++;
            $display("FAIL underrun_pulse: got underrun=%b cur=%h expected 1 %h", underrun_o, dut.cur, SMP_B);
        end
        @(negedge clk_i);
        checks++;
        if (underrun_o !== 1'b0) begin
            errors++;
            $display("FAIL underrun_width: got %b expected 0", underrun_o);
        end
    endtask

    task automatic test_tick_and_transfer();
        sample_i = SMP_C;
        valid_i  = 1'b1;
        do_tick();
        valid_i = 1'b0;
        checks++;
        if (underrun_o !== 1'b1 || ready_o !== 1'b0 || dut.cur !== SMP_B) begin
            errors++;
            $display("FAIL simul_edge: got underrun=%b ready=%b cur=%h expected 1 0 %h",
                     underrun_o, ready_o, dut.cur, SMP_B);
        end
        @(negedge clk_i);
        do_tick();
        checks++;
        if (dut.cur !== SMP_C || underrun_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL simul_next_tick: got cur=%h underrun=%b ready=%b expected %h 0 1",
                     dut.cur, underrun_o, ready_o, SMP_C);
        end
    endtask

`ifdef SAMPLE_DAC_UNDERRUN_CNT_EN
    task automatic test_underrun_cnt();
        checks++;
        if (underrun_cnt_o !== 8'd2) begin
            errors++;
            $display("FAIL cnt_start: got %0d expected 2", underrun_cnt_o);
        end
        repeat (300) begin
            do_tick();
            @(negedge clk_i);
        end
        checks++;
        if (underrun_cnt_o !== UNDERRUN_CNT_MAX) begin
            errors++;
            $display("FAIL cnt_saturate: got %0d expected 255", underrun_cnt_o);
        end
    endtask
`endif

    task automatic test_reset_mid_pending();
        int ones;
        @(negedge clk_i);
        push(SMP_D);
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b1 || dac_o !== 1'b0 || underrun_o !== 1'b0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL rst_mid: got ready=%b dac=%b underrun=%b state=%b expected 1 0 0 IDLE",
                     ready_o, dac_o, underrun_o, dut.state);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        do_tick();
        checks++;
        if (underrun_o !== 1'b0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL rst_idle_tick: got underrun=%b state=%b expected 0 IDLE", underrun_o, dut.state);
        end
        ones = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_i);
            if (dac_o === 1'b1) ones++;
        end
        checks++;
        if (ones != 500) begin
            errors++;
            $display("FAIL rst_density: got %0d expected 500", ones);
        end
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_idle_midscale();
        test_extreme(16'h8000, 0, 0);
        test_extreme(16'h7FFF, 999, 1000);
        test_back_to_back();
        test_underrun();
        test_tick_and_transfer();
`ifdef SAMPLE_DAC_UNDERRUN_CNT_EN
        test_underrun_cnt();
`endif
        test_reset_mid_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
